// File: rtl/register_file.sv
// Parametrised general-purpose register bank: one synchronous write port,
// two independent registered read ports with write-through bypass, and a per-entry written mask.
module register_file #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re_a,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [WIDTH-1:0]  rdata_a,
    output logic              rvalid_a,
    input  logic              re_b,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  rdata_b,
    output logic              rvalid_b,
    output logic [DEPTH-1:0]  written
);

    // One extra bit so DEPTH itself is representable when 2^ADDR_W == DEPTH.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [DEPTH-1:0] written_r;
    logic [WIDTH-1:0] rdata_a_r;
    logic [WIDTH-1:0] rdata_b_r;
    logic             rvalid_a_r;
    logic             rvalid_b_r;

    logic             wen_s;
    logic             a_in_range_s;
    logic             b_in_range_s;
    logic [WIDTH-1:0] rd_a_s;
    logic [WIDTH-1:0] rd_b_s;

    // Qualify the write and the read addresses against the populated range.
    always_comb begin
        wen_s        = we & ({1'b0, waddr} < DEPTH_L);
        a_in_range_s = ({1'b0, raddr_a} < DEPTH_L);
        b_in_range_s = ({1'b0, raddr_b} < DEPTH_L);
    end

    // Port A read mux: out-of-range reads yield zero, same-address writes bypass the array.
    always_comb begin
        rd_a_s = '0;
        if (!a_in_range_s) begin
            rd_a_s = '0;
        end else if (wen_s && (waddr == raddr_a)) begin
            rd_a_s = wdata;
        end else begin
            rd_a_s = mem_r[raddr_a];
        end
    end

    // Port B read mux, same rules as port A.
    always_comb begin
        rd_b_s = '0;
        if (!b_in_range_s) begin
            rd_b_s = '0;
        end else if (wen_s && (waddr == raddr_b)) begin
            rd_b_s = wdata;
        end else begin
            rd_b_s = mem_r[raddr_b];
        end
    end

    // Storage array and written mask; reset overrides any write on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            written_r <= '0;
        end else if (wen_s) begin
            mem_r[waddr]     <= wdata;
            written_r[waddr] <= 1'b1;
        end
    end

    // Read output registers; data holds when idle while valid drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_a_r  <= '0;
            rdata_b_r  <= '0;
            rvalid_a_r <= 1'b0;
            rvalid_b_r <= 1'b0;
        end else begin
            rvalid_a_r <= re_a;
            rvalid_b_r <= re_b;
            if (re_a) begin
                rdata_a_r <= rd_a_s;
            end
            if (re_b) begin
                rdata_b_r <= rd_b_s;
            end
        end
    end

    assign rdata_a  = rdata_a_r;
    assign rdata_b  = rdata_b_r;
    assign rvalid_a = rvalid_a_r;
    assign rvalid_b = rvalid_b_r;
    assign written  = written_r;

endmodule
